if_fetch_unit: RTL and testbench

- Instruction-fetch stage that sits around the PC register.
- Consumes the current PC, drives the instruction-memory request handshake and computes the next PC fed back to the PC register's input.
- Captures fetched instructions into the IF/ID pipeline register.
- Handles hazard stalls, taken-branch/jump redirects, and variable-latency memory responses, including discarding stale in-flight fetches.

---
 rtl/if_fetch_unit.sv | 138 +++++++++++++
 tb/tb_if_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives the imem request around the PC register,
// computes the next PC and fills the IF/ID pipeline register.
module if_fetch_unit #(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_pc,
  output logic [N-1:0] o_next_pc,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [N-1:0] imem_rdata,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_target,
  output logic         id_valid,
  output logic [N-1:0] id_pc,
  output logic [N-1:0] id_pc4,
  output logic [N-1:0] id_inst
);

  localparam int unsigned  SW   = 2;
  localparam logic [N-1:0] FOUR = N'(4);

  localparam logic [SW-1:0] ST_FETCH = 2'd0;
  localparam logic [SW-1:0] ST_WAIT  = 2'd1;
  localparam logic [SW-1:0] ST_HOLD  = 2'd2;
  localparam logic [SW-1:0] ST_DROP  = 2'd3;

  logic [SW-1:0] state_q, state_d;
  logic [N-1:0]  addr_q, addr_d;
  logic [N-1:0]  hold_q, hold_d;
  logic          valid_d;
  logic [N-1:0]  pc_d, pc4_d, inst_d;
  logic [N-1:0]  fetch_addr;
  logic [N-1:0]  next_pc;
  logic          wr;
  logic [N-1:0]  wr_pc, wr_inst;

  // Address of the fetch being requested: live PC in FETCH, captured PC after.
  assign fetch_addr = (state_q == ST_FETCH) ? i_pc : addr_q;
  assign imem_addr  = fetch_addr;
  assign imem_req   = !rst && (state_q != ST_HOLD);
  assign o_next_pc  = rst ? RESET_PC : next_pc;

  // Next-state, IF/ID update and next-PC selection.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    valid_d = id_valid;
    pc_d    = id_pc;
    pc4_d   = id_pc4;
    inst_d  = id_inst;
    next_pc = i_pc;
    wr      = 1'b0;
    wr_pc   = fetch_addr;
    wr_inst = imem_rdata;

    if (state_q == ST_FETCH) begin
      addr_d = i_pc;
    end

    case (state_q)
      ST_FETCH, ST_WAIT: begin
        if (redirect_valid) begin
          state_d = (state_q == ST_WAIT && !imem_ready) ? ST_DROP : ST_FETCH;
        end else if (imem_ready) begin
          if (stall) begin
            hold_d  = imem_rdata;
            state_d = ST_HOLD;
          end else begin
            wr      = 1'b1;
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          state_d = ST_FETCH;
        end else if (!stall) begin
          wr      = 1'b1;
          wr_pc   = i_pc;
          wr_inst = hold_q;
          state_d = ST_FETCH;
        end
      end
      ST_DROP: begin
        // The stale response is swallowed; a redirect here only retargets the PC.
        if (imem_ready) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    if (redirect_valid) begin
      next_pc = redirect_target;
      valid_d = 1'b0;
      inst_d  = '0;
    end else if (wr) begin
      next_pc = wr_pc + FOUR;
      valid_d = 1'b1;
      pc_d    = wr_pc;
      pc4_d   = wr_pc + FOUR;
      inst_d  = wr_inst;
    end else if (!stall) begin
      valid_d = 1'b0;
      inst_d  = '0;
    end
  end

  // State and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      addr_q   <= '0;
      hold_q   <= '0;
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_pc4   <= '0;
      id_inst  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      hold_q   <= hold_d;
      id_valid <= valid_d;
      id_pc    <= pc_d;
      id_pc4   <= pc4_d;
      id_inst  <= inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: PC register and variable-latency memory around the
// DUT, directed scenarios plus random traffic against a transaction-level model.
module tb_if_fetch_unit;

  localparam int unsigned N        = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XMASK    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_q = 32'hDEAD_BEE0;
  logic [31:0] o_next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic [31:0] id_pc, id_pc4, id_inst;

  int n_checks = 0;
  int n_pass   = 0;
  int mem_lat  = 0;
  int mem_left = -1;

  logic [31:0] s_next, s_addr;
  logic        s_req;

  // Reference model: flags describing what the fetch stage owes the pipeline.
  logic        m_live, m_stale, m_held;
  logic [31:0] m_held_inst, m_fetch_pc;
  logic        e_req, e_valid;
  logic [31:0] e_next, e_addr, e_pc, e_pc4, e_inst;

  always #5 clk = ~clk;
  always @(posedge clk) pc_q <= o_next_pc;

  if_fetch_unit #(.N(N), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .i_pc(pc_q), .o_next_pc(o_next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .id_valid(id_valid), .id_pc(id_pc),
    .id_pc4(id_pc4), .id_inst(id_inst)
  );

  task automatic model_step();
    logic wrote;
    wrote = 1'b0;
    if (rst) begin
      e_next = RESET_PC; e_req = 1'b0; e_addr = 32'h0;
      m_live = 1'b0; m_stale = 1'b0; m_held = 1'b0;
      e_valid = 1'b0; e_pc = 32'h0; e_pc4 = 32'h0; e_inst = 32'h0;
    end else begin
      e_req  = !m_held;
      e_addr = (m_live || m_stale) ? m_fetch_pc : pc_q;
      e_next = pc_q;
      if (redirect_valid) begin
        e_next = redirect_target; e_valid = 1'b0; e_inst = 32'h0;
        if (m_stale) m_stale = !imem_ready;
        else if (m_held) m_held = 1'b0;
        else begin m_stale = m_live && !imem_ready; m_live = 1'b0; end
      end else if (m_stale) begin
        if (imem_ready) m_stale = 1'b0;
      end else if (m_held) begin
        if (!stall) begin
          wrote = 1'b1; e_valid = 1'b1; e_pc = pc_q; e_pc4 = pc_q + 32'd4;
          e_inst = m_held_inst; e_next = pc_q + 32'd4; m_held = 1'b0;
        end
      end else if (imem_ready) begin
        m_live = 1'b0;
        if (stall) begin
          m_held = 1'b1; m_held_inst = imem_rdata;
        end else begin
          wrote = 1'b1; e_valid = 1'b1; e_pc = e_addr; e_pc4 = e_addr + 32'd4;
          e_inst = imem_rdata; e_next = e_addr + 32'd4;
        end
      end else begin
        if (!m_live) m_fetch_pc = e_addr;
        m_live = 1'b1;
      end
      if (!redirect_valid && !stall && !wrote) begin e_valid = 1'b0; e_inst = 32'h0; end
    end
  endtask

  // One clock: drive inputs, let memory answer, sample comb outputs, clock, settle.
  task automatic drive_cycle(input logic r, input logic st, input logic rv, input logic [31:0] tgt);
    rst = r; stall = st; redirect_valid = rv; redirect_target = tgt;
    #1;
    if (r || !imem_req) begin
      mem_left = -1; imem_ready = 1'b0;
    end else begin
      if (mem_left < 0) mem_left = mem_lat;
      if (mem_left == 0) begin imem_ready = 1'b1; mem_left = -1; end
      else begin imem_ready = 1'b0; mem_left--; end
    end
    imem_rdata = imem_ready ? (imem_addr ^ XMASK) : $urandom;
    #1;
    s_next = o_next_pc; s_req = imem_req; s_addr = imem_addr;
    model_step();
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    mem_lat = 0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++; if (s_next !== RESET_PC) $display("FAIL reset_next_pc got=%h exp=%h", s_next, RESET_PC); else n_pass++;
      n_checks++; if (s_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", s_req); else n_pass++;
      n_checks++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid got=%b exp=0", id_valid); else n_pass++;
      n_checks++; if ({id_pc, id_pc4, id_inst} !== 96'h0) $display("FAIL reset_id got=%h/%h/%h exp=0", id_pc, id_pc4, id_inst); else n_pass++;
    end
  endtask

  task automatic test_zero_latency();
    logic [31:0] ep;
    mem_lat = 0;
    for (int i = 0; i < 4; i++) begin
      ep = 32'(4 * i);
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++; if (s_addr !== ep) $display("FAIL zl_addr got=%h exp=%h", s_addr, ep); else n_pass++;
      n_checks++; if (s_next !== ep + 32'd4) $display("FAIL zl_next got=%h exp=%h", s_next, ep + 32'd4); else n_pass++;
      n_checks++; if (id_valid !== 1'b1 || id_pc !== ep || id_pc4 !== ep + 32'd4) $display("FAIL zl_id got=%b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_pc4, ep, ep + 32'd4); else n_pass++;
      n_checks++; if (id_inst !== (ep ^ XMASK)) $display("FAIL zl_inst got=%h exp=%h", id_inst, ep ^ XMASK); else n_pass++;
    end
  endtask

  task automatic test_latency3();
    logic [31:0] base;
    mem_lat = 3;
    for (int k = 0; k < 2; k++) begin
      base = 32'h10 + 32'(4 * k);
      for (int j = 0; j < 3; j++) begin
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++; if (s_req !== 1'b1 || s_addr !== base) $display("FAIL lat_addr got=%b/%h exp=1/%h", s_req, s_addr, base); else n_pass++;
        n_checks++; if (s_next !== base) $display("FAIL lat_hold_pc got=%h exp=%h", s_next, base); else n_pass++;
        n_checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0) $display("FAIL lat_bubble got=%b/%h exp=0/0", id_valid, id_inst); else n_pass++;
      end
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++; if (s_next !== base + 32'd4) $display("FAIL lat_next got=%h exp=%h", s_next, base + 32'd4); else n_pass++;
      n_checks++; if (id_valid !== 1'b1 || id_pc !== base || id_inst !== (base ^ XMASK)) $display("FAIL lat_id got=%b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_inst, base, base ^ XMASK); else n_pass++;
    end
  endtask

  task automatic test_stall_response();
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    mem_lat = 0;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    mem_lat = 1;
    for (int c = 1; c <= 4; c++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      n_checks++; if (s_next !== 32'h8) $display("FAIL stall_next c%0d got=%h exp=8", c, s_next); else n_pass++;
      n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_inst !== (32'h4 ^ XMASK)) $display("FAIL stall_frozen c%0d got=%b/%h/%h exp=1/4/%h", c, id_valid, id_pc, id_inst, 32'h4 ^ XMASK); else n_pass++;
      n_checks++; if (s_req !== (c <= 2)) $display("FAIL stall_req c%0d got=%b exp=%b", c, s_req, c <= 2); else n_pass++;
    end
    mem_lat = 0;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (s_next !== 32'hC || s_req !== 1'b0) $display("FAIL release_next got=%h/%b exp=c/0", s_next, s_req); else n_pass++;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_pc4 !== 32'hC || id_inst !== (32'h8 ^ XMASK)) $display("FAIL release_id got=%b/%h/%h/%h exp=1/8/c/%h", id_valid, id_pc, id_pc4, id_inst, 32'h8 ^ XMASK); else n_pass++;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (s_addr !== 32'hC || id_pc !== 32'hC || id_valid !== 1'b1) $display("FAIL after_hold got=%h/%h/%b exp=c/c/1", s_addr, id_pc, id_valid); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    mem_lat = 0;
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    mem_lat = 3;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (s_addr !== 32'h10) $display("FAIL rw_req_addr got=%h exp=10", s_addr); else n_pass++;
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h100);
    n_checks++; if (s_next !== 32'h100 || id_valid !== 1'b0) $display("FAIL rw_redirect got=%h/%b exp=100/0", s_next, id_valid); else n_pass++;
    for (int c = 0; c < 2; c++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h10) $display("FAIL rw_drop_addr got=%b/%h exp=1/10", s_req, s_addr); else n_pass++;
      n_checks++; if (s_next !== 32'h100 || id_valid !== 1'b0) $display("FAIL rw_drop got=%h/%b exp=100/0", s_next, id_valid); else n_pass++;
    end
    mem_lat = 0;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (s_addr !== 32'h100) $display("FAIL rw_new_addr got=%h exp=100", s_addr); else n_pass++;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== (32'h100 ^ XMASK)) $display("FAIL rw_id got=%b/%h/%h exp=1/100/%h", id_valid, id_pc, id_inst, 32'h100 ^ XMASK); else n_pass++;
  endtask

  task automatic test_redirect_stall();
    mem_lat = 0;
    drive_cycle(1'b0, 1'b1, 1'b1, 32'h40);
    n_checks++; if (s_next !== 32'h40) $display("FAIL rs_next got=%h exp=40", s_next); else n_pass++;
    n_checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0) $display("FAIL rs_flush got=%b/%h exp=0/0", id_valid, id_inst); else n_pass++;
    n_checks++; if (pc_q !== 32'h40) $display("FAIL rs_pc got=%h exp=40", pc_q); else n_pass++;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (s_addr !== 32'h40 || id_valid !== 1'b1 || id_pc !== 32'h40) $display("FAIL rs_refetch got=%h/%b/%h exp=40/1/40", s_addr, id_valid, id_pc); else n_pass++;
  endtask

  task automatic test_wrap_reset();
    mem_lat = 0;
    drive_cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (s_addr !== 32'hFFFF_FFFC || s_next !== 32'h0) $display("FAIL wrap_next got=%h/%h exp=fffffffc/0", s_addr, s_next); else n_pass++;
    n_checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0 || id_valid !== 1'b1) $display("FAIL wrap_id got=%h/%h/%b exp=fffffffc/0/1", id_pc, id_pc4, id_valid); else n_pass++;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    mem_lat = 3;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (s_addr !== 32'h4 || s_next !== 32'h4) $display("FAIL mr_wait got=%h/%h exp=4/4", s_addr, s_next); else n_pass++;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++; if (s_next !== RESET_PC || s_req !== 1'b0 || id_valid !== 1'b0) $display("FAIL mr_reset got=%h/%b/%b exp=%h/0/0", s_next, s_req, id_valid, RESET_PC); else n_pass++;
    mem_lat = 0;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (s_addr !== RESET_PC || id_valid !== 1'b1 || id_pc !== RESET_PC) $display("FAIL mr_restart got=%h/%b/%h exp=%h/1/%h", s_addr, id_valid, id_pc, RESET_PC, RESET_PC); else n_pass++;
  endtask

  task automatic test_random();
    logic r, st, rv;
    logic [31:0] tgt;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 99) < 30);
      rv  = ($urandom_range(0, 99) < 10);
      tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      mem_lat = $urandom_range(0, 3);
      drive_cycle(r, st, rv, tgt);
      n_checks++; if (s_next !== e_next) $display("FAIL rnd_next cyc%0d got=%h exp=%h", i, s_next, e_next); else n_pass++;
      n_checks++; if (s_req !== e_req) $display("FAIL rnd_req cyc%0d got=%b exp=%b", i, s_req, e_req); else n_pass++;
      if (e_req) begin
        n_checks++; if (s_addr !== e_addr) $display("FAIL rnd_addr cyc%0d got=%h exp=%h", i, s_addr, e_addr); else n_pass++;
      end
      n_checks++; if (id_valid !== e_valid) $display("FAIL rnd_valid cyc%0d got=%b exp=%b", i, id_valid, e_valid); else n_pass++;
      n_checks++; if (id_pc !== e_pc || id_pc4 !== e_pc4) $display("FAIL rnd_pc cyc%0d got=%h/%h exp=%h/%h", i, id_pc, id_pc4, e_pc, e_pc4); else n_pass++;
      n_checks++; if (id_inst !== e_inst) $display("FAIL rnd_inst cyc%0d got=%h exp=%h", i, id_inst, e_inst); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    m_live = 1'b0; m_stale = 1'b0; m_held = 1'b0; m_held_inst = 32'h0; m_fetch_pc = 32'h0;
    e_req = 1'b0; e_valid = 1'b0; e_next = 32'h0; e_addr = 32'h0;
    e_pc = 32'h0; e_pc4 = 32'h0; e_inst = 32'h0;
    @(negedge clk);
    test_reset();
    test_zero_latency();
    test_latency3();
    test_stall_response();
    test_redirect_wait();
    test_redirect_stall();
    test_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
